// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port synchronous RAM: fixed priority for m0,
// bounded wait for m1, and one-cycle read return steered to the issuing master.
module ram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_M0   = 2'd1,
    RD_M1   = 2'd2
  } rd_owner_e;

  logic [CNT_W-1:0] starve_cnt_r;
  rd_owner_e        rd_owner_r;
  logic             m0_rvalid_r;
  logic             m1_rvalid_r;
  logic             starved_s;
  logic             m0_win_s;
  logic             m1_win_s;

  // Winner selection; grants are suppressed while reset is asserted.
  always_comb begin
    starved_s = (starve_cnt_r == LIM);
    m1_win_s  = 1'b0;
    m0_win_s  = 1'b0;
    if (resetn) begin
      m1_win_s = m1_req & (~m0_req | starved_s);
      m0_win_s = m0_req & ~m1_win_s;
    end else begin
      m1_win_s = 1'b0;
      m0_win_s = 1'b0;
    end
  end

  assign m0_gnt = m0_win_s;
  assign m1_gnt = m1_win_s;

  // RAM port mux: the winner's request goes straight to the RAM, idle drives zero.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (m0_win_s) begin
      ram_we   = m0_we;
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
    end else if (m1_win_s) begin
      ram_we   = m1_we;
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
    end else begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
    end
  end

  // Starvation counter and read-owner tracking with registered rvalid strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_r <= '0;
      rd_owner_r   <= RD_NONE;
      m0_rvalid_r  <= 1'b0;
      m1_rvalid_r  <= 1'b0;
    end else begin
      if (m1_req && !m1_win_s) begin
        starve_cnt_r <= starved_s ? starve_cnt_r : starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= '0;
      end
      if (m0_win_s && !m0_we) begin
        rd_owner_r  <= RD_M0;
        m0_rvalid_r <= 1'b1;
        m1_rvalid_r <= 1'b0;
      end else if (m1_win_s && !m1_we) begin
        rd_owner_r  <= RD_M1;
        m0_rvalid_r <= 1'b0;
        m1_rvalid_r <= 1'b1;
      end else begin
        rd_owner_r  <= RD_NONE;
        m0_rvalid_r <= 1'b0;
        m1_rvalid_r <= 1'b0;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  // Both masters see the RAM output directly; rvalid qualifies it.
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

  ram_arbiter_chk u_chk (
    .clk       (clk),
    .resetn    (resetn),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .ram_we    (ram_we),
    .owner_m0  (rd_owner_r == RD_M0),
    .owner_m1  (rd_owner_r == RD_M1)
  );

endmodule

// Protocol invariants of the arbiter, kept apart from the datapath.
module ram_arbiter_chk (
  input logic clk,
  input logic resetn,
  input logic m0_req,
  input logic m1_req,
  input logic m0_gnt,
  input logic m1_gnt,
  input logic m0_rvalid,
  input logic m1_rvalid,
  input logic ram_we,
  input logic owner_m0,
  input logic owner_m1
);

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!resetn) !(m0_gnt && m1_gnt));
  a_gnt0_req:   assert property (@(posedge clk) disable iff (!resetn) m0_gnt |-> m0_req);
  a_gnt1_req:   assert property (@(posedge clk) disable iff (!resetn) m1_gnt |-> m1_req);
  a_rv_onehot:  assert property (@(posedge clk) disable iff (!resetn) !(m0_rvalid && m1_rvalid));
  a_we_granted: assert property (@(posedge clk) disable iff (!resetn) ram_we |-> (m0_gnt || m1_gnt));
  a_rv0_owner:  assert property (@(posedge clk) disable iff (!resetn) m0_rvalid == owner_m0);
  a_rv1_owner:  assert property (@(posedge clk) disable iff (!resetn) m1_rvalid == owner_m1);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed table of vectors, reset corner sequences and
// randomized traffic checked against a cycle-level behavioural model with a RAM.
module tb_ram_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_we;
  logic [31:0] m0_rdata, m1_rdata, ram_din;
  logic [9:0]  ram_addr;
  logic [31:0] ram_dout = '0;
  logic [31:0] ram_mem [0:1023];

  ram_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIM(LIM)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM; output register changes only on read cycles.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout <= ram_mem[ram_addr];
  end

  typedef struct {
    logic r0, w0; logic [9:0] a0; logic [31:0] d0;
    logic r1, w1; logic [9:0] a1; logic [31:0] d1;
    logic g0, g1, v0, v1; logic [31:0] rd;
  } vec_t;
  vec_t tab[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: how long m1 has waited, the outstanding read, memory image.
  int          wait_cnt = 0;
  int          pend_owner = -1;
  logic [31:0] pend_data = '0;
  logic [31:0] ref_mem [0:1023];
  int          last_win = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r0, w0, input logic [9:0] a0, input logic [31:0] d0,
                     input logic r1, w1, input logic [9:0] a1, input logic [31:0] d1,
                     input logic g0, g1, v0, v1, input logic [31:0] rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    tab.push_back(v);
  endtask

  // One clock cycle: drive, compare against the model (and optional table row), advance model.
  task automatic cycle(input vec_t v, input logic use_tab);
    int win;
    logic [31:0] e_addr, e_din;
    logic e_we;
    @(negedge clk);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    if (v.r0 && v.r1) win = (wait_cnt >= LIM) ? 1 : 0;
    else if (v.r0)    win = 0;
    else if (v.r1)    win = 1;
    else              win = -1;
    e_we = 1'b0; e_addr = '0; e_din = '0;
    if (win == 0) begin e_we = v.w0; e_addr = {22'd0, v.a0}; e_din = v.d0; end
    if (win == 1) begin e_we = v.w1; e_addr = {22'd0, v.a1}; e_din = v.d1; end
    #1;
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, win == 0});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, win == 1});
    chk("ram_we", {31'd0, ram_we}, {31'd0, e_we});
    chk("ram_addr", {22'd0, ram_addr}, e_addr);
    chk("ram_din", ram_din, e_din);
    chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, pend_owner == 0});
    chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, pend_owner == 1});
    if (pend_owner == 0) chk("m0_rdata", m0_rdata, pend_data);
    if (pend_owner == 1) chk("m1_rdata", m1_rdata, pend_data);
    if (use_tab) begin
      chk("tab_m0_gnt", {31'd0, m0_gnt}, {31'd0, v.g0});
      chk("tab_m1_gnt", {31'd0, m1_gnt}, {31'd0, v.g1});
      chk("tab_m0_rvalid", {31'd0, m0_rvalid}, {31'd0, v.v0});
      chk("tab_m1_rvalid", {31'd0, m1_rvalid}, {31'd0, v.v1});
      if (v.v0) chk("tab_m0_rdata", m0_rdata, v.rd);
      if (v.v1) chk("tab_m1_rdata", m1_rdata, v.rd);
    end
    @(posedge clk);
    pend_owner = -1;
    if (win == 0) begin
      if (v.w0) ref_mem[v.a0] = v.d0;
      else begin pend_owner = 0; pend_data = ref_mem[v.a0]; end
    end else if (win == 1) begin
      if (v.w1) ref_mem[v.a1] = v.d1;
      else begin pend_owner = 1; pend_data = ref_mem[v.a1]; end
    end
    if (v.r1 && win != 1) wait_cnt = (wait_cnt + 1 > LIM) ? LIM : wait_cnt + 1;
    else                  wait_cnt = 0;
    last_win = win;
  endtask

  // Short async reset pulse placed between two clock edges.
  task automatic pulse_reset();
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    wait_cnt = 0;
    pend_owner = -1;
  endtask

  function automatic logic [9:0] pick_addr();
    case ($urandom_range(5))
      0: return 10'h000;
      1: return 10'h001;
      2: return 10'h002;
      3: return 10'h003;
      4: return 10'h005;
      default: return 10'h3FF;
    endcase
  endfunction

  initial begin
    vec_t v;
    logic p1;
    // Reset held with both masters requesting: nothing may be granted.
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
      chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    end
    @(posedge clk);
    #2 resetn = 1'b1;

    // m0 write, m1 read-back of the same word.
    add(1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 1'b1, 1'b0, 10'h005, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, 10'h005, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Both masters reading continuously: m1 breaks through every fifth cycle.
    p1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      add(1'b1, 1'b0, 10'h005, 32'd0, 1'b1, 1'b0, 10'h005, 32'd0,
          !(k == 4 || k == 9), (k == 4 || k == 9), (k > 0) && !p1, (k > 0) && p1, 32'hDEADBEEF);
      p1 = (k == 4 || k == 9);
    end
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    // Preload 0..3 then four back-to-back m0 reads.
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b1, 10'(i), 32'(16 + i), 1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b0, 10'(i), 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, i > 0, 1'b0, 32'(15 + i));
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13);
    // Top address by m1 alone, including write immediately followed by read.
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b1, 10'h3FF, 32'hA5A55A5A, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, 10'h3FF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5A55A5A);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b1, 1'b0, 10'h3FF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add(1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 10'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678);
    foreach (tab[i]) cycle(tab[i], 1'b1);

    // Reset between an m1 read grant and its response: the response is dropped.
    v = tab[tab.size() - 2];
    cycle(v, 1'b1);
    pulse_reset();
    v = tab[2];
    v.v1 = 1'b0;
    cycle(v, 1'b1);
    // Reset clears accumulated m1 wait: a full window of m0 wins is needed again.
    v = tab[3];
    for (int k = 0; k < 3; k++) begin v.v0 = (k > 0); cycle(v, 1'b1); end
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      v.g0 = (k < 4); v.g1 = (k == 4); v.v0 = (k > 0); v.v1 = 1'b0;
      cycle(v, 1'b1);
    end

    // Randomized traffic; a master keeps its request until granted or occasionally withdraws.
    v = tab[2];
    for (int n = 0; n < 400; n++) begin
      if (!(v.r0 && last_win != 0 && $urandom_range(9) != 0)) begin
        v.r0 = ($urandom_range(2) != 0); v.w0 = $urandom_range(1) == 1;
        v.a0 = pick_addr(); v.d0 = $urandom;
      end
      if (!(v.r1 && last_win != 1 && $urandom_range(9) != 0)) begin
        v.r1 = ($urandom_range(2) != 0); v.w1 = $urandom_range(1) == 1;
        v.a1 = pick_addr(); v.d1 = $urandom;
      end
      cycle(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
